fifo_ctrl: RTL and testbench
============================

Name: fifo_ctrl

Overview:
- Pointer and flag controller for the circular FIFO; sits directly upstream of the FIFO register-file storage.
- Converts producer push and consumer pop requests into the register file's write enable, write address and read address.
- Tracks occupancy and reports full, empty, almost-full, almost-empty and sticky overflow/underflow status.
- Read data is taken combinationally from the register file at read_address, so the FIFO is first-word-fall-through: the head word is visible whenever empty=0.

Parameters:
- address_width, 3, log2 of FIFO depth; depth = 2**address_width; must match the register file's address_width.
- almost_full_margin, 1, almost_full asserts when count >= depth - almost_full_margin.
- almost_empty_margin, 1, almost_empty asserts when count <= almost_empty_margin.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- wr  input  1  push request; the data word is driven to the register file's write_data by the producer in the same cycle.
- rd  input  1  pop request; consumes the word currently at read_address.
- w_en  output  1  write strobe to the register file.
- write_address  output  address_width  register-file write address.
- read_address  output  address_width  register-file read address (head of FIFO).
- full  output  1  FIFO holds depth words.
- empty  output  1  FIFO holds 0 words.
- almost_full  output  1  occupancy threshold flag.
- almost_empty  output  1  occupancy threshold flag.
- count  output  address_width+1  current occupancy, 0..depth.
- overflow  output  1  sticky: a push was attempted while full.
- underflow  output  1  sticky: a pop was attempted while empty.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values: write pointer=0, read pointer=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0.
- Reset priority: reset overrides wr/rd in the same cycle.
- Reset mid-operation: all contents are logically discarded; register-file storage is not cleared.
- Registered state: write pointer, read pointer, count, full, empty, overflow, underflow.
- Address outputs: write_address and read_address are the registered pointers.
- Derived flags: almost_full and almost_empty are combinational from registered count, so they add no extra latency.
- Accepted push: push_ok = wr & ~full.
  - w_en = push_ok (combinational, same cycle as wr).
  - Write pointer increments on the next edge.
- Accepted pop: pop_ok = rd & ~empty; read pointer increments on the next edge.
- Pointer wrap: pointers increment modulo depth (7 -> 0 for depth 8); no skipped or duplicated addresses.
- Push only (push_ok & ~pop_ok): count+1; empty->0; full->1 when count was depth-1.
- Pop only (pop_ok & ~push_ok): count-1; full->0; empty->1 when count was 1.
- Simultaneous push and pop, both accepted: both pointers advance; count, full and empty unchanged.
- Write while full: rejected even if rd is also asserted that cycle.
  - w_en=0, pointer and count unchanged; only the pop takes effect.
  - overflow sets on the next edge.
- Read while empty: rejected even if wr is also asserted that cycle.
  - Read pointer unchanged; only the push takes effect.
  - underflow sets on the next edge.
- Sticky flags: overflow and underflow clear only on reset.
- Read latency: a pushed word is visible at read_address one cycle after its write edge, when empty falls; no extra latency.
- Invariants:
  - full and empty never both 1.
  - count == (write pointer - read pointer) mod depth, except count == depth when full.

Test Plan:
- Reset then idle -> empty=1, full=0, count=0, almost_empty=1, w_en=0, both addresses 0, overflow=underflow=0.
- 8 consecutive pushes (depth 8) -> w_en high each cycle, write_address 0..7; almost_full at count=7; full=1 and count=8 after the 8th push; write_address wraps to 0.
- 9th push while full with rd=0 -> w_en=0, count stays 8, overflow=1 next cycle and persists; then 8 pops -> read_address 0..7 returns data in push order; empty=1 at end.
- Pop while empty -> read_address unchanged, count=0, underflow=1 next cycle; a simultaneous wr in that cycle is accepted, giving count=1.
- Fill to 3, then 20 cycles of wr=rd=1 -> count stays 3, both pointers wrap past 7 -> 0, data order preserved, no flag changes.
- Fill to 5, assert reset for 1 cycle with wr=1 -> next cycle count=0, empty=1, pointers 0, sticky flags cleared, w_en follows wr & ~full.

Source files
------------

// File: rtl/fifo_ctrl.sv
// Pointer and flag controller for a first-word-fall-through circular FIFO.
// Drives the register file's write strobe and addresses; storage contents are never cleared here.
module fifo_ctrl #(
    parameter int address_width       = 3,
    parameter int almost_full_margin  = 1,
    parameter int almost_empty_margin = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr,
    input  logic                     rd,
    output logic                     w_en,
    output logic [address_width-1:0] write_address,
    output logic [address_width-1:0] read_address,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [address_width:0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int aw    = address_width;
    localparam int cw    = address_width + 1;
    localparam int depth = 2 ** address_width;

    localparam logic [cw-1:0] almost_full_level  = cw'(depth - almost_full_margin);
    localparam logic [cw-1:0] almost_empty_level = cw'(almost_empty_margin);
    localparam logic [cw-1:0] last_free_level    = cw'(depth - 1);

    logic [aw-1:0] wr_ptr_q, wr_ptr_d;
    logic [aw-1:0] rd_ptr_q, rd_ptr_d;
    logic [cw-1:0] count_q,  count_d;
    logic          full_q,   full_d;
    logic          empty_q,  empty_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;

    logic push_ok;
    logic pop_ok;

    // Requests are qualified against the registered flags only, so a pop never frees a slot
    // for a push in the same cycle.
    assign push_ok = wr & ~full_q;
    assign pop_ok  = rd & ~empty_q;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        full_d      = full_q;
        empty_d     = empty_q;
        overflow_d  = overflow_q | (wr & full_q);
        underflow_d = underflow_q | (rd & empty_q);

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + aw'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + aw'(1);
        end

        unique case ({push_ok, pop_ok})
            2'b10: begin
                count_d = count_q + cw'(1);
                empty_d = 1'b0;
                full_d  = (count_q == last_free_level);
            end
            2'b01: begin
                count_d = count_q - cw'(1);
                full_d  = 1'b0;
                empty_d = (count_q == cw'(1));
            end
            default: begin
                // Idle or balanced push+pop: occupancy and fill flags hold.
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign w_en          = push_ok;
    assign write_address = wr_ptr_q;
    assign read_address  = rd_ptr_q;
    assign count         = count_q;
    assign full          = full_q;
    assign empty         = empty_q;
    assign overflow      = overflow_q;
    assign underflow     = underflow_q;

    // Thresholds decode straight off the registered count, adding no latency.
    assign almost_full  = (count_q >= almost_full_level);
    assign almost_empty = (count_q <= almost_empty_level);

endmodule

// File: tb/tb_fifo_ctrl.sv
// Scoreboard bench for fifo_ctrl: stimulus queues expected per-cycle outputs and pushed data,
// a negedge monitor pops and compares; a behavioural register file supplies read data.
module tb_fifo_ctrl;

    localparam int AW    = 3;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr;
    logic          rd;
    logic          w_en;
    logic [AW-1:0] write_address;
    logic [AW-1:0] read_address;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;

    logic [7:0]    wdata;
    logic [7:0]    mem [DEPTH];

    fifo_ctrl #(
        .address_width      (AW),
        .almost_full_margin (1),
        .almost_empty_margin(1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wr           (wr),
        .rd           (rd),
        .w_en         (w_en),
        .write_address(write_address),
        .read_address (read_address),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (w_en) mem[write_address] <= wdata;
    end

    typedef struct {
        logic          w_en;
        logic [AW-1:0] wa;
        logic [AW-1:0] ra;
        logic [AW:0]   cnt;
        logic          full;
        logic          empty;
        logic          af;
        logic          ae;
        logic          ovf;
        logic          unf;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] data_sb[$];

    int n_compared   = 0;
    int n_mismatched = 0;

    int m_count = 0;
    int m_wp    = 0;
    int m_rp    = 0;
    bit m_ovf   = 1'b0;
    bit m_unf   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_compared++;
        if (act !== req) begin
            n_mismatched++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // One clock cycle of stimulus; queues the outputs expected during it, then advances the model.
    task automatic cycle(input logic w, input logic r, input logic rst, input logic [7:0] d);
        exp_t e;
        bit   push_ok;
        bit   pop_ok;
        wr    = w;
        rd    = r;
        reset = rst;
        wdata = d;
        e.w_en  = w && (m_count != DEPTH);
        e.wa    = AW'(m_wp);
        e.ra    = AW'(m_rp);
        e.cnt   = (AW+1)'(m_count);
        e.full  = (m_count == DEPTH);
        e.empty = (m_count == 0);
        e.af    = (m_count >= DEPTH - 1);
        e.ae    = (m_count <= 1);
        e.ovf   = m_ovf;
        e.unf   = m_unf;
        exp_q.push_back(e);
        @(posedge clk);
        if (rst) begin
            m_count = 0;
            m_wp    = 0;
            m_rp    = 0;
            m_ovf   = 1'b0;
            m_unf   = 1'b0;
            data_sb.delete();
        end else begin
            push_ok = w && (m_count < DEPTH);
            pop_ok  = r && (m_count > 0);
            if (w && !push_ok) m_ovf = 1'b1;
            if (r && !pop_ok)  m_unf = 1'b1;
            if (push_ok) begin
                m_wp = (m_wp + 1) % DEPTH;
                data_sb.push_back(d);
            end
            if (pop_ok) m_rp = (m_rp + 1) % DEPTH;
            m_count = m_count + int'(push_ok) - int'(pop_ok);
        end
        #1;
    endtask

    task automatic push_n(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, base + 8'(i));
    endtask

    task automatic pop_n(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("w_en",          w_en,          e.w_en);
                check("write_address", write_address, e.wa);
                check("read_address",  read_address,  e.ra);
                check("count",         count,         e.cnt);
                check("full",          full,          e.full);
                check("empty",         empty,         e.empty);
                check("almost_full",   almost_full,   e.af);
                check("almost_empty",  almost_empty,  e.ae);
                check("overflow",      overflow,      e.ovf);
                check("underflow",     underflow,     e.unf);
                if (rd && !empty && !reset) begin
                    if (data_sb.size() == 0) begin
                        n_compared++;
                        n_mismatched++;
                        $display("FAIL rd_data: pop presented with no word outstanding (t=%0t)", $time);
                    end else begin
                        check("rd_data", mem[read_address], data_sb.pop_front());
                    end
                end
            end
        end
    end

    initial begin : stimulus
        reset = 1'b1;
        wr    = 1'b0;
        rd    = 1'b0;
        wdata = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state and idle.
        cycle(1'b0, 1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 1'b0, 8'h00);
        check("rst_empty",        empty,         1);
        check("rst_full",         full,          0);
        check("rst_count",        count,         0);
        check("rst_almost_empty", almost_empty,  1);
        check("rst_w_en",         w_en,          0);
        check("rst_wa",           write_address, 0);
        check("rst_ra",           read_address,  0);

        // Fill to depth; write pointer wraps back to 0.
        push_n(7, 8'hA0);
        check("af_at_7", almost_full, 1);
        push_n(1, 8'hA7);
        check("full_after_8",  full,          1);
        check("count_after_8", count,         8);
        check("wa_wrap",       write_address, 0);

        // Push while full is rejected; overflow is sticky.
        cycle(1'b1, 1'b0, 1'b0, 8'hEE);
        check("ovf_count", count,    8);
        check("ovf_set",   overflow, 1);
        cycle(1'b0, 1'b0, 1'b0, 8'h00);
        check("ovf_sticky", overflow, 1);

        // Drain in push order.
        pop_n(8);
        check("drained_empty", empty,        1);
        check("drained_ra",    read_address, 0);

        // Pop while empty with a simultaneous push: only the push lands.
        cycle(1'b1, 1'b1, 1'b0, 8'h51);
        check("unf_count", count,        1);
        check("unf_set",   underflow,    1);
        check("unf_ra",    read_address, 0);

        // Fill to 3, then 20 balanced cycles wrapping both pointers.
        push_n(2, 8'h52);
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1, 1'b0, 8'h60 + 8'(i));
        check("bal_count", count,         3);
        check("bal_wa",    write_address, 7);
        check("bal_ra",    read_address,  4);
        check("bal_full",  full,          0);
        check("bal_empty", empty,         0);
        pop_n(3);

        // Reset with wr asserted mid-operation.
        push_n(5, 8'hC0);
        cycle(1'b1, 1'b0, 1'b1, 8'hCF);
        check("mid_rst_count", count,         0);
        check("mid_rst_empty", empty,         1);
        check("mid_rst_wa",    write_address, 0);
        check("mid_rst_ra",    read_address,  0);
        check("mid_rst_ovf",   overflow,      0);
        check("mid_rst_unf",   underflow,     0);

        // Full with wr and rd together: pop proceeds, push rejected.
        push_n(8, 8'h10);
        cycle(1'b1, 1'b1, 1'b0, 8'hFF);
        check("full_rw_count", count,    7);
        check("full_rw_full",  full,     0);
        check("full_rw_ovf",   overflow, 1);
        pop_n(7);
        check("final_empty", empty, 1);

        wr = 1'b0;
        rd = 1'b0;
        @(negedge clk);
        if (exp_q.size() != 0) begin
            n_compared++;
            n_mismatched++;
            $display("FAIL drain: %0d expectations never compared", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
